// File: rtl/mem_bus_arbiter_if.sv
// Requester, grant/read-return and memory-port signals between the cpu/dma
// requesters, the arbiter and the synchronous memory.
interface mem_bus_arbiter_if #(
  parameter int unsigned AW = 16,
  parameter int unsigned DW = 8
);
  logic          cpu_req;
  logic          cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic          cpu_gnt;
  logic          cpu_rvld;

  logic          dma_req;
  logic          dma_we;
  logic [AW-1:0] dma_addr;
  logic [DW-1:0] dma_wdata;
  logic          dma_gnt;
  logic          dma_rvld;

  logic [DW-1:0] rdata;

  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  // Arbiter view
  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_gnt, cpu_rvld,
    input  dma_req, dma_we, dma_addr, dma_wdata,
    output dma_gnt, dma_rvld,
    output rdata,
    output mem_addr, mem_we, mem_wdata,
    input  mem_rdata
  );

  // Requester and memory view
  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_gnt, cpu_rvld,
    output dma_req, dma_we, dma_addr, dma_wdata,
    input  dma_gnt, dma_rvld,
    input  rdata,
    input  mem_addr, mem_we, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Two-requester (cpu, dma) arbiter for a single synchronous memory port:
// cpu-first out of idle, bounded-streak alternation under contention.
module mem_bus_arbiter #(
  parameter int unsigned AW       = 16,
  parameter int unsigned DW       = 8,
  parameter int unsigned HOLD_MAX = 4
) (
  input logic              CLK,
  input logic              R,
  mem_bus_arbiter_if.slave bus
);

  localparam int unsigned     SW         = $clog2(HOLD_MAX + 1);
  localparam logic [SW-1:0]   STREAK_MAX = SW'(HOLD_MAX);

  typedef enum logic [1:0] {
    LAST_NONE = 2'd0,
    LAST_CPU  = 2'd1,
    LAST_DMA  = 2'd2
  } last_e;

  last_e         last_q, last_d;
  logic [SW-1:0] streak_q, streak_d;
  logic          cpu_rvld_q, dma_rvld_q;

  logic          cpu_gnt_c, dma_gnt_c;
  logic          hold_ok_c;
  logic [SW-1:0] streak_inc_c;
  logic [AW-1:0] addr_c;
  logic [DW-1:0] wdata_c;
  logic          we_c;

  // State register
  always_ff @(posedge CLK) begin
    if (R) begin
      last_q     <= LAST_NONE;
      streak_q   <= '0;
      cpu_rvld_q <= 1'b0;
      dma_rvld_q <= 1'b0;
    end else begin
      last_q     <= last_d;
      streak_q   <= streak_d;
      cpu_rvld_q <= cpu_gnt_c & ~bus.cpu_we;
      dma_rvld_q <= dma_gnt_c & ~bus.dma_we;
    end
  end

  // Grant decision, next state and memory-port mux
  always_comb begin
    cpu_gnt_c    = 1'b0;
    dma_gnt_c    = 1'b0;
    last_d       = LAST_NONE;
    streak_d     = '0;
    hold_ok_c    = (streak_q < STREAK_MAX);
    streak_inc_c = hold_ok_c ? (streak_q + SW'(1)) : STREAK_MAX;
    addr_c       = bus.cpu_addr;
    wdata_c      = bus.cpu_wdata;
    we_c         = 1'b0;

    if (!R) begin
      if (bus.cpu_req && !bus.dma_req) begin
        cpu_gnt_c = 1'b1;
      end else if (bus.dma_req && !bus.cpu_req) begin
        dma_gnt_c = 1'b1;
      end else if (bus.cpu_req && bus.dma_req) begin
        case (last_q)
          LAST_CPU: begin
            cpu_gnt_c = hold_ok_c;
            dma_gnt_c = ~hold_ok_c;
          end
          LAST_DMA: begin
            dma_gnt_c = hold_ok_c;
            cpu_gnt_c = ~hold_ok_c;
          end
          default:  cpu_gnt_c = 1'b1;
        endcase
      end
    end

    // Streak saturates at HOLD_MAX; a change of owner restarts it at 1
    if (cpu_gnt_c) begin
      last_d   = LAST_CPU;
      streak_d = (last_q == LAST_CPU) ? streak_inc_c : SW'(1);
      we_c     = bus.cpu_we;
    end else if (dma_gnt_c) begin
      last_d   = LAST_DMA;
      streak_d = (last_q == LAST_DMA) ? streak_inc_c : SW'(1);
      addr_c   = bus.dma_addr;
      wdata_c  = bus.dma_wdata;
      we_c     = bus.dma_we;
    end
  end

  assign bus.cpu_gnt   = cpu_gnt_c;
  assign bus.dma_gnt   = dma_gnt_c;
  assign bus.cpu_rvld  = cpu_rvld_q;
  assign bus.dma_rvld  = dma_rvld_q;
  assign bus.rdata     = bus.mem_rdata;
  assign bus.mem_addr  = addr_c;
  assign bus.mem_we    = we_c;
  assign bus.mem_wdata = wdata_c;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scoreboard bench for mem_bus_arbiter: instance 0 has HOLD_MAX=4, instance 1
// has HOLD_MAX=1; directed vectors push expected grants/read returns.
module tb_mem_bus_arbiter;

  localparam logic [15:0] CA = 16'h1234;
  localparam logic [15:0] DA = 16'h0300;

  typedef struct {
    int          sel;
    logic [1:0]  who;
    logic        we;
    logic        chk;
    logic [15:0] addr;
    logic [7:0]  wd;
  } gexp_t;

  typedef struct {
    int         sel;
    logic [1:0] who;
    logic [7:0] data;
    int         due;
  } rexp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  gexp_t q_g[$];
  rexp_t q_r[$];

  logic [1:0]  rst_v   = 2'b11;
  logic [1:0]  cpu_req = 2'b00;
  logic [1:0]  cpu_we  = 2'b00;
  logic [1:0]  dma_req = 2'b00;
  logic [1:0]  dma_we  = 2'b00;
  logic [15:0] cpu_addr  [2];
  logic [7:0]  cpu_wdata [2];
  logic [15:0] dma_addr  [2];
  logic [7:0]  dma_wdata [2];

  logic [1:0]  o_cgnt, o_dgnt, o_crv, o_drv, o_mwe;
  logic [15:0] o_maddr [2];
  logic [7:0]  o_mwd   [2];
  logic [7:0]  o_rdata [2];

  // Memory contents seen by every reader: one preloaded word, the rest a hash
  function automatic logic [7:0] exp_rd(input logic [15:0] a);
    if (a == 16'h1234) return 8'hA5;
    return a[7:0] ^ a[15:8] ^ 8'h5A;
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int unsigned HM = (g == 0) ? 4 : 1;

    mem_bus_arbiter_if #(.AW(16), .DW(8)) bus ();

    mem_bus_arbiter #(.AW(16), .DW(8), .HOLD_MAX(HM)) u_dut (
      .CLK (clk),
      .R   (rst_v[g]),
      .bus (bus.slave)
    );

    assign bus.cpu_req   = cpu_req[g];
    assign bus.cpu_we    = cpu_we[g];
    assign bus.cpu_addr  = cpu_addr[g];
    assign bus.cpu_wdata = cpu_wdata[g];
    assign bus.dma_req   = dma_req[g];
    assign bus.dma_we    = dma_we[g];
    assign bus.dma_addr  = dma_addr[g];
    assign bus.dma_wdata = dma_wdata[g];

    assign o_cgnt[g]  = bus.cpu_gnt;
    assign o_dgnt[g]  = bus.dma_gnt;
    assign o_crv[g]   = bus.cpu_rvld;
    assign o_drv[g]   = bus.dma_rvld;
    assign o_mwe[g]   = bus.mem_we;
    assign o_maddr[g] = bus.mem_addr;
    assign o_mwd[g]   = bus.mem_wdata;
    assign o_rdata[g] = bus.rdata;

    // Synchronous memory: read data appears the cycle after the address
    logic [7:0] mem [logic [15:0]];
    always @(posedge clk) begin
      bus.mem_rdata <= mem.exists(bus.mem_addr) ? mem[bus.mem_addr] : exp_rd(bus.mem_addr);
      if (bus.mem_we) mem[bus.mem_addr] = bus.mem_wdata;
    end
  end

  // Monitor: pops expectations whenever a grant/valid is (or should be) presented
  always @(negedge clk) begin
    gexp_t      g;
    rexp_t      r;
    logic [1:0] who, rv;
    bit         mis;
    for (int s = 0; s < 2; s++) begin
      who = {o_dgnt[s], o_cgnt[s]};
      rv  = {o_drv[s], o_crv[s]};
      if (q_g.size() != 0 && q_g[0].sel == s) begin
        g   = q_g.pop_front();
        n_cmp++;
        mis = (who !== g.who) || (o_mwe[s] !== g.we) ||
              (g.chk && ((o_maddr[s] !== g.addr) || (o_mwd[s] !== g.wd)));
        if (mis) begin
          n_bad++;
          $display("FAIL grant[%0d] cyc=%0d: got who=%0d we=%b addr=%h wdata=%h, want who=%0d we=%b addr=%h wdata=%h",
                   s, cyc, who, o_mwe[s], o_maddr[s], o_mwd[s], g.who, g.we, g.addr, g.wd);
        end
      end else if (who !== 2'b00) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_grant[%0d] cyc=%0d: got who=%0d, want none", s, cyc, who);
      end

      if (rv !== 2'b00) begin
        n_cmp++;
        if (q_r.size() != 0 && q_r[0].sel == s) begin
          r = q_r.pop_front();
          if ((rv !== r.who) || (o_rdata[s] !== r.data) || (r.due != cyc)) begin
            n_bad++;
            $display("FAIL rvld[%0d] cyc=%0d: got rvld=%b rdata=%h, want rvld=%b rdata=%h at cyc=%0d",
                     s, cyc, rv, o_rdata[s], r.who, r.data, r.due);
          end
        end else begin
          n_bad++;
          $display("FAIL unexpected_rvld[%0d] cyc=%0d: got rvld=%b, want 00", s, cyc, rv);
        end
      end else if (q_r.size() != 0 && q_r[0].sel == s && q_r[0].due <= cyc) begin
        r = q_r.pop_front();
        n_cmp++;
        n_bad++;
        $display("FAIL missing_rvld[%0d] cyc=%0d: got rvld=00, want rvld=%b rdata=%h", s, cyc, r.who, r.data);
      end
    end
  end

  // One cycle of stimulus; eg = expected grant (0 none, 1 cpu, 2 dma).
  // lrst raises R after the grant is observed, inside the same cycle.
  task automatic cyc_v(input int s, input bit rst, input bit lrst,
                       input bit cr, input bit cw, input logic [15:0] ca, input logic [7:0] cd,
                       input bit dr, input bit dw, input logic [15:0] da, input logic [7:0] dd,
                       input logic [1:0] eg);
    gexp_t g;
    rexp_t r;
    bit    rd;
    @(posedge clk);
    #1;
    rst_v[s]     = rst;
    cpu_req[s]   = cr;
    cpu_we[s]    = cw;
    cpu_addr[s]  = ca;
    cpu_wdata[s] = cd;
    dma_req[s]   = dr;
    dma_we[s]    = dw;
    dma_addr[s]  = da;
    dma_wdata[s] = dd;
    g.sel = s;
    g.who = eg;
    if (eg == 2'd1) begin
      g.we = cw; g.addr = ca; g.wd = cd; g.chk = 1'b1;
    end else if (eg == 2'd2) begin
      g.we = dw; g.addr = da; g.wd = dd; g.chk = 1'b1;
    end else begin
      g.we = 1'b0; g.addr = ca; g.wd = cd; g.chk = !rst;
    end
    q_g.push_back(g);
    rd = (eg != 2'd0) && !g.we;
    if (rd) begin
      r.sel = s; r.who = eg; r.data = exp_rd(g.addr); r.due = cyc + 1;
      q_r.push_back(r);
    end
    if (lrst) begin
      @(negedge clk);
      #1;
      rst_v[s] = 1'b1;
      if (rd) void'(q_r.pop_back());
    end
  endtask

  task automatic t_both(input int s, input logic [1:0] eg);
    cyc_v(s, 0, 0, 1, 0, CA, 8'h11, 1, 0, DA, 8'h22, eg);
  endtask

  task automatic t_cpu(input int s);
    cyc_v(s, 0, 0, 1, 0, CA, 8'h11, 0, 0, DA, 8'h22, 2'd1);
  endtask

  task automatic t_dma(input int s);
    cyc_v(s, 0, 0, 0, 0, CA, 8'h11, 1, 0, DA, 8'h22, 2'd2);
  endtask

  task automatic t_idle(input int s);
    cyc_v(s, 0, 0, 0, 0, CA, 8'h00, 0, 0, DA, 8'h00, 2'd0);
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      cpu_addr[i] = '0; cpu_wdata[i] = '0; dma_addr[i] = '0; dma_wdata[i] = '0;
    end

    // Reset with both requesting writes: no grant, mem_we low
    for (int s = 0; s < 2; s++) begin
      cyc_v(s, 1, 0, 1, 1, CA, 8'hEE, 1, 1, DA, 8'hDD, 2'd0);
      cyc_v(s, 1, 0, 1, 1, CA, 8'hEE, 1, 1, DA, 8'hDD, 2'd0);
    end
    t_idle(1);
    t_idle(0);

    // Uncontended cpu read of 0x1234 -> 0xA5 next cycle
    t_cpu(0);
    t_idle(0);

    // Uncontended dma write, no read return
    cyc_v(0, 0, 0, 0, 0, CA, 8'h00, 1, 1, 16'h0200, 8'h3C, 2'd2);
    t_idle(0);

    // Sustained contention from idle: CPUx4, DMAx4, CPUx4, DMAx4
    for (int i = 0; i < 16; i++) t_both(0, ((i / 4) % 2 == 0) ? 2'd1 : 2'd2);
    t_idle(0);

    // cpu drops after two grants, then re-requests while dma runs its streak
    t_both(0, 2'd1);
    t_both(0, 2'd1);
    t_dma(0);
    t_both(0, 2'd2);
    t_both(0, 2'd2);
    t_both(0, 2'd2);
    t_both(0, 2'd1);
    t_idle(0);

    // Back-to-back: cpu read then dma write; the read still returns
    t_cpu(0);
    cyc_v(0, 0, 0, 0, 0, CA, 8'h00, 1, 1, 16'h0204, 8'h77, 2'd2);
    t_idle(0);

    // Reset lands on the edge after a cpu read grant: result discarded
    cyc_v(0, 0, 1, 1, 0, CA, 8'h11, 0, 0, DA, 8'h22, 2'd1);
    cyc_v(0, 1, 0, 1, 0, CA, 8'h11, 1, 0, DA, 8'h22, 2'd0);
    cyc_v(0, 1, 0, 1, 0, CA, 8'h11, 1, 0, DA, 8'h22, 2'd0);
    t_both(0, 2'd1);
    t_idle(0);

    // HOLD_MAX=1: strict alternation with read ownership tracking
    for (int i = 0; i < 8; i++) t_both(1, (i % 2 == 0) ? 2'd1 : 2'd2);
    t_idle(1);
    t_cpu(1);
    t_cpu(1);
    t_both(1, 2'd2);
    t_both(1, 2'd1);
    t_idle(1);
    t_idle(1);
    t_idle(0);

    @(negedge clk);
    #1;
    n_cmp++;
    if (q_g.size() != 0 || q_r.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d grant and %0d read expectations left, want 0 and 0", q_g.size(), q_r.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
